// File: rtl/puf_meas_ctrl.sv
// puf_meas_ctrl: measurement sequencer for the ring-oscillator PUF array.
// For each of NBITS oscillator pairs it selects a ring pair, clears the
// ripple counters, runs the rings for WINDOW cycles, lets the counters
// settle, then shifts one comparison bit into the response register.
//
// Handshake: start is a level sampled only in IDLE (abort has priority
// there); busy is high from the accept edge until the edge entering DONE;
// done is a one-cycle pulse, and resp/resp_valid hold until the next
// accepted start. abort cancels a run in progress without a done pulse.
module puf_meas_ctrl #(
  parameter int WINDOW  = 64,
  parameter int SETTLE  = 4,
  parameter int CLR_CYC = 2,
  parameter int NBITS   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       challenge,
  input  logic [7:0]       count_a,
  input  logic [7:0]       count_b,
  output logic             osc_en,
  output logic             cnt_clr,
  output logic [4:0]       sel_a,
  output logic [4:0]       sel_b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] resp,
  output logic             resp_valid,
  output logic             sat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [3:0]  k;
  logic [3:0]  k_inc;
  logic [4:0]  chal;
  logic [4:0]  sel_next;
  logic        active;
  logic        abort_hit;
  logic        start_hit;

  // The rst_n pin is active-high in this codebase despite its name.
  assign active    = (state == S_CLEAR) || (state == S_RUN) ||
                     (state == S_SETTLE) || (state == S_SAMPLE);
  assign abort_hit = active && abort;
  assign start_hit = (state == S_IDLE) && start && !abort;
  assign k_inc     = k + 4'd1;
  // Base select of the next pair: challenge + 2(k+1), wrapping mod 32.
  assign sel_next  = chal + {k_inc, 1'b0};

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: each timed phase ends when the timer reaches its length.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start_hit) state_next = S_CLEAR;
      S_CLEAR:  if (timer == 16'(CLR_CYC - 1)) state_next = S_RUN;
      S_RUN:    if (timer == 16'(WINDOW - 1)) state_next = S_SETTLE;
      S_SETTLE: if (timer == 16'(SETTLE - 1)) state_next = S_SAMPLE;
      S_SAMPLE: state_next = (k == 4'(NBITS - 1)) ? S_DONE : S_CLEAR;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  // Phase timer: restarts on every state change, idle in IDLE.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      timer <= 16'd0;
    end else if ((state_next != state) || (state == S_IDLE)) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // Registered outputs, pair index, selects and response accumulation.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      osc_en     <= 1'b0;
      cnt_clr    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sel_a      <= 5'd0;
      sel_b      <= 5'd0;
      resp       <= '0;
      resp_valid <= 1'b0;
      sat        <= 1'b0;
      k          <= 4'd0;
      chal       <= 5'd0;
    end else begin
      // Decoding from state_next keeps these glitch-free and aligned with
      // the state they belong to; osc_en and cnt_clr are never both set.
      osc_en  <= (state_next == S_RUN);
      cnt_clr <= (state_next == S_IDLE) || (state_next == S_CLEAR) ||
                 (state_next == S_DONE);
      busy    <= !((state_next == S_IDLE) || (state_next == S_DONE));
      done    <= (state_next == S_DONE);

      if (start_hit) begin
        chal       <= challenge;
        k          <= 4'd0;
        resp       <= '0;
        sat        <= 1'b0;
        resp_valid <= 1'b0;
        sel_a      <= challenge;
        sel_b      <= challenge + 5'd1;
      end

      if (abort_hit) begin
        resp       <= '0;
        resp_valid <= 1'b0;
      end else if (state == S_SAMPLE) begin
        for (int i = 0; i < NBITS; i++) begin
          if (k == 4'(i)) resp[i] <= (count_a > count_b);
        end
        sat <= sat | (count_a == 8'hFF) | (count_b == 8'hFF);
        // Selects move only on entry to CLEAR, while the rings are off.
        if (state_next == S_CLEAR) begin
          k     <= k_inc;
          sel_a <= sel_next;
          sel_b <= sel_next + 5'd1;
        end
      end

      if (state_next == S_DONE) resp_valid <= 1'b1;
    end
  end

endmodule

// File: doc/puf_meas_ctrl.md
# puf_meas_ctrl

Measurement sequencer for the ring-oscillator PUF array. It walks a challenge through NBITS oscillator pairs. For each pair it selects the two ring outputs on the two 32:1 muxes, clears both ripple counters, enables the rings for a fixed window, then disables them and lets the counters settle. It then compares the two counts and shifts one response bit into a result register. It sits between the host-facing pins and the two oscillator-bank/mux/counter datapaths.

## Interface
Parameters:
- WINDOW, 64: clk cycles the oscillators are enabled per pair (1..65535)
- SETTLE, 4: clk cycles after disable before counts are sampled (≥2)
- CLR_CYC, 2: clk cycles cnt_clr is held per pair (≥1)
- NBITS, 8: response bits per challenge (1..16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  begin a measurement; sampled only in IDLE
- abort  in  1  cancel the measurement in progress; return to IDLE
- challenge  in  5  base mux index for pair 0
- count_a  in  8  ripple counter value, bank A
- count_b  in  8  ripple counter value, bank B
- osc_en  out  1  oscillator enable (drives `ena` of both banks)
- cnt_clr  out  1  counter clear, active-high
- sel_a  out  5  bank-A mux select
- sel_b  out  5  bank-B mux select
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  one-cycle pulse when the response completes
- resp  out  NBITS  response, bit k = result of pair k
- resp_valid  out  1  resp holds a complete result
- sat  out  1  sticky: some sampled count was 8'hFF during this run

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE.
- Reset values: state=IDLE, osc_en=0, cnt_clr=1, sel_a=sel_b=0, busy=0, done=0, resp=0, resp_valid=0, sat=0, pair index k=0, timer=0.
- IDLE: cnt_clr=1, osc_en=0. If start=1:
  - latch challenge;
  - k←0, resp←0, sat←0, resp_valid←0;
  - go to CLEAR.
- CLEAR: cnt_clr=1, osc_en=0, held CLR_CYC cycles; then RUN.
- RUN: cnt_clr=0, osc_en=1, held WINDOW cycles; then SETTLE.
- SETTLE: osc_en=0, cnt_clr=0, held SETTLE cycles. This allows the last ring edges to ripple through the asynchronous counters before sampling.
- SAMPLE (1 cycle):
  - resp[k] ← (count_a > count_b), unsigned; a tie gives 0;
  - sat ← sat | (count_a==8'hFF) | (count_b==8'hFF);
  - if k==NBITS-1 go to DONE, else k←k+1 and go to CLEAR.
- DONE (1 cycle): done=1, resp_valid←1; go to IDLE. resp and resp_valid hold until the next accepted start.
- Selects, computed mod 32 (5-bit wrap): sel_a = challenge + 2k, sel_b = challenge + 2k + 1. Selects change only on entry to CLEAR, never while osc_en=1.
- start while busy is ignored. start and abort together in IDLE: abort wins and start is ignored.
- abort while busy: next state IDLE, osc_en←0, cnt_clr←1, resp_valid←0, resp←0, no done pulse.
- rst_n asserted mid-run forces all reset values immediately (asynchronous); osc_en drops without waiting for clk.
- count_a/count_b are read only in SAMPLE. No synchronizer is required because the counters are quiescent for ≥SETTLE cycles by then.

## Timing
- Per pair: CLR_CYC + WINDOW + SETTLE + 1 cycles. With defaults that is 71.
- The edge that accepts start is edge 0. The done pulse is high in the cycle after edge NBITS·(CLR_CYC+WINDOW+SETTLE+1). With defaults that is edge 568.
- osc_en is registered: it rises on the edge entering RUN and falls on the edge entering SETTLE, giving exactly WINDOW high cycles.
- resp_valid rises with done; resp bits update only on SAMPLE edges.
- busy rises on the start-accept edge and falls on the edge entering DONE.

## Test plan
- Reset: assert rst_n mid-RUN. Required: osc_en=0, cnt_clr=1, busy=0, resp=0 and IDLE immediately; after release, start proceeds normally.
- Basic run, defaults, challenge=5, count_a=100 / count_b=90 on even pairs and 80/90 on odd pairs. Required:
  - resp=8'h55, done at edge 568, resp_valid=1, sat=0;
  - sel_a/sel_b sequence 5/6, 7/8, …, 19/20.
- Wrap and tie, challenge=30, NBITS=8. Required: pair 1 selects 0/1, pair 7 selects 12/13. With equal counts on every pair, resp=0.
- Window length: WINDOW=10, SETTLE=2. Count clk cycles with osc_en=1. Required: exactly 10 per pair; cnt_clr high exactly CLR_CYC cycles before each window; osc_en and cnt_clr never both high.
- Abort and start while busy:
  - start pulsed during RUN is ignored;
  - abort during pair 3 gives IDLE next cycle with no done, resp_valid=0;
  - a new start runs a full NBITS sequence.
- Saturation: count_b=8'hFF at pair 2. Required: sat=1 at done and cleared by the next start.
